// File: rtl/weight_pkg.sv
// -----------------------------------------------------------------------------
// weight_pkg
//   Shared definitions for the weight load controller and its shadow buffer:
//   the controller state encoding, default geometry (16-bit words, 5x5 kernel)
//   and the word-counter width helper.
// -----------------------------------------------------------------------------
package weight_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        HOLD   = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_N          = 25;

    // Counter must be able to hold the value N (one past the last weight slot),
    // which is also the index of the checksum beat when that feature is built.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/weight_shadow_buffer.sv
// -----------------------------------------------------------------------------
// weight_shadow_buffer
//   Index-addressed packer: on wr_en, word wr_idx of an N-word shadow bus is
//   replaced by wr_data. Word k occupies words[k*DATA_WIDTH +: DATA_WIDTH].
//   Indices >= N write nothing.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low clear (all words -> 0)
//   wr_en    in   write enable
//   wr_idx   in   IDX_W-bit slot index
//   wr_data  in   DATA_WIDTH-bit word
//   words    out  N*DATA_WIDTH packed shadow bus
// -----------------------------------------------------------------------------
module weight_shadow_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 25,
    parameter int IDX_W      = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [N*DATA_WIDTH-1:0] words
);

    logic [N-1:0][DATA_WIDTH-1:0] words_q;
    logic [N-1:0][DATA_WIDTH-1:0] words_d;

    // NOTE: every signal assigned in always_comb gets its default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        words_d = words_q;
        if (wr_en) begin
            for (int k = 0; k < N; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    words_d[k] = wr_data;
                end
            end
        end
    end

    // NOTE: this storage is reset on purpose: the shadow bus drives the weight
    // register directly and must read as all-zero after reset. Plain data
    // arrays with no such need are better left without a reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign words = words_q;

endmodule

// File: rtl/weight_load_controller.sv
// -----------------------------------------------------------------------------
// weight_load_controller
//   Loads the N-entry convolver weight register from a valid/ready word stream.
//   Words are packed into a shadow bus (first word in slot 0); once all N are
//   in, the controller waits until the convolver is idle and then issues a
//   single-cycle write/done so weights never change under a running
//   convolution. abort (LOAD/HOLD) or reset discards the load without a write.
//
// Optional feature (macro WEIGHT_LOAD_CHECKSUM_EN):
//   A checksum word follows the N weights; it must equal the sum of the
//   weights mod 2^DATA_WIDTH. A mismatch pulses checksum_err and returns to
//   IDLE with no write. Without the macro exactly N beats are taken and
//   checksum_err is constant 0.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   start         in   begin a load (IDLE only, abort has priority)
//   abort         in   drop the load in progress (LOAD/HOLD)
//   w_valid       in   stream word valid
//   w_data        in   stream weight word
//   w_ready       out  word accepted this cycle (decoded from state)
//   conv_busy     in   convolver busy; blocks the commit
//   weight_write  out  packed shadow bus, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   write         out  1-cycle commit strobe
//   busy          out  controller not IDLE
//   done          out  1-cycle pulse with write
//   checksum_err  out  1-cycle pulse on checksum mismatch
// -----------------------------------------------------------------------------
module weight_load_controller
    import weight_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N          = DEF_N
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    w_valid,
    input  logic [DATA_WIDTH-1:0]   w_data,
    output logic                    w_ready,
    input  logic                    conv_busy,
    output logic [N*DATA_WIDTH-1:0] weight_write,
    output logic                    write,
    output logic                    busy,
    output logic                    done,
    output logic                    checksum_err
);

    localparam int CW = cnt_width(N);

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    // Beat N carries the checksum word.
    localparam logic [CW-1:0] LAST_IDX = CW'(N);
`else
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            write_q, write_d;
    logic            done_q,  done_d;
    logic            busy_q,  busy_d;
    logic            beat;
    logic            store;

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  err_q, err_d;
`endif

    assign w_ready = (state_q == LOAD);
    assign beat    = w_valid && w_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        write_d = 1'b0;
        done_d  = 1'b0;
        store   = 1'b0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD;
                    count_d = '0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end

            LOAD: begin
                if (abort) begin
                    // A beat coinciding with abort is dropped, not stored.
                    state_d = IDLE;
                    count_d = '0;
                end else if (beat) begin
                    count_d = count_q + 1'b1;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
                    if (count_q == LAST_IDX) begin
                        if (w_data == sum_q) begin
                            state_d = HOLD;
                        end else begin
                            state_d = IDLE;
                            count_d = '0;
                            err_d   = 1'b1;
                        end
                    end else begin
                        store = 1'b1;
                        sum_d = sum_q + w_data;
                    end
`else
                    store = 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = HOLD;
                    end
`endif
                end
            end

            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!conv_busy) begin
                    // Strobes are registered, so they go high together with
                    // the COMMIT state itself.
                    state_d = COMMIT;
                    write_d = 1'b1;
                    done_d  = 1'b1;
                end
            end

            COMMIT: begin
                state_d = IDLE;
                count_d = '0;
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        // Registered copy of "not IDLE" that tracks the state register exactly.
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            write_q <= write_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign checksum_err = err_q;
`else
    assign checksum_err = 1'b0;
`endif

    weight_shadow_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .IDX_W      (CW)
    ) u_shadow (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (store),
        .wr_idx  (count_q),
        .wr_data (w_data),
        .words   (weight_write)
    );

    assign write = write_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule
